// File: rtl/roll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : roll_scheduler
// Brief    : Sequencing controller for the 4-bit LFSR dice datapath. Loads the
//            seed on start, issues step pulses on a decelerating tick schedule,
//            captures the settled value and keeps a one-deep roll history.
// Revision : 1.0 - initial release
// ============================================================================
module roll_scheduler #(
  parameter int TICK_W    = 23,
  parameter int LAST_TICK = 14
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_recall,
  input  logic [3:0] i_rand,
  output logic       o_load_seed,
  output logic       o_step,
  output logic [3:0] o_result,
  output logic [3:0] o_prev,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Tick counter terminal value and the value one cycle before it. Steps are
  // registered, so the decision is taken in the cycle before the tick event.
  localparam logic [TICK_W-1:0] C_CNT_MAX  = '1;
  localparam logic [TICK_W-1:0] C_CNT_PRE  = C_CNT_MAX ^ TICK_W'(1);
  localparam logic [3:0]        C_LAST_IDX = 4'(LAST_TICK);
  // Six steps per roll; index of the final one.
  localparam logic [2:0]        C_LAST_STEP = 3'd5;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [TICK_W-1:0] w_tick_cnt_nxt;
  logic [3:0]        r_tick_idx;
  logic [3:0]        w_tick_idx_nxt;
  logic [2:0]        r_step_idx;
  logic [2:0]        w_step_idx_nxt;
  logic [3:0]        r_last;
  logic [3:0]        w_last_nxt;
  logic [3:0]        w_result_nxt;
  logic [3:0]        w_prev_nxt;
  logic              w_load_nxt;
  logic              w_step_nxt;
  logic              w_done_nxt;
  logic [3:0]        w_idx_inc;

  // Decelerating schedule: tick indices at which the LFSR advances.
  function automatic logic is_step_tick(input logic [3:0] idx);
    return (idx == 4'd1) || (idx == 4'd2) || (idx == 4'd4) ||
           (idx == 4'd7) || (idx == 4'd10) || (idx == C_LAST_IDX);
  endfunction

  assign w_idx_inc = r_tick_idx + 4'd1;
  assign o_busy    = (r_state != S_IDLE);

  // Next-state and next-output decode; every target holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_tick_idx_nxt = r_tick_idx;
    w_step_idx_nxt = r_step_idx;
    w_last_nxt     = r_last;
    w_result_nxt   = o_result;
    w_prev_nxt     = o_prev;
    w_load_nxt     = 1'b0;
    w_step_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_result_nxt = i_recall ? o_prev : r_last;
        if (i_start) begin
          w_state_nxt    = S_RUN;
          w_load_nxt     = 1'b1;
          w_tick_cnt_nxt = '0;
          w_tick_idx_nxt = 4'd0;
          w_step_idx_nxt = 3'd0;
        end
      end
      S_RUN: begin
        w_result_nxt = i_rand;
        if (i_start) begin
          // Restart: the aborted roll leaves no trace in the history.
          w_load_nxt     = 1'b1;
          w_tick_cnt_nxt = '0;
          w_tick_idx_nxt = 4'd0;
          w_step_idx_nxt = 3'd0;
        end else if (i_stop || (o_step && (r_step_idx == C_LAST_STEP))) begin
          // A step already on the output this cycle still completes.
          w_state_nxt = S_FINISH;
        end else begin
          w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          if ((r_tick_cnt == C_CNT_MAX) && (r_tick_idx != C_LAST_IDX)) begin
            w_tick_idx_nxt = w_idx_inc;
          end
          w_step_nxt = (r_tick_cnt == C_CNT_PRE) && is_step_tick(w_idx_inc);
          if (o_step) begin
            w_step_idx_nxt = r_step_idx + 3'd1;
          end
        end
      end
      S_FINISH: begin
        w_result_nxt = i_rand;
        w_prev_nxt   = r_last;
        w_last_nxt   = i_rand;
        w_done_nxt   = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, history and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt  <= '0;
      r_tick_idx  <= 4'd0;
      r_step_idx  <= 3'd0;
      r_last      <= 4'd0;
      o_result    <= 4'd0;
      o_prev      <= 4'd0;
      o_load_seed <= 1'b0;
      o_step      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_tick_idx  <= w_tick_idx_nxt;
      r_step_idx  <= w_step_idx_nxt;
      r_last      <= w_last_nxt;
      o_result    <= w_result_nxt;
      o_prev      <= w_prev_nxt;
      o_load_seed <= w_load_nxt;
      o_step      <= w_step_nxt;
      o_done      <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_roll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_roll_scheduler
// Brief    : Scoreboard bench for roll_scheduler with a behavioural LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roll_scheduler;

  typedef struct {
    int cyc;
    int res;
    int prv;
  } done_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       recall  = 1'b0;
  logic [3:0] rnd     = 4'd0;
  logic       load_seed;
  logic       step;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] prev;

  int    cyc   = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    b;
  int    step_ofs[6] = '{4, 8, 16, 28, 40, 56};
  int    load_q[$];
  int    step_q[$];
  done_t done_q[$];

  roll_scheduler #(
    .TICK_W    (2),
    .LAST_TICK (14)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .i_recall    (recall),
    .i_rand      (rnd),
    .o_load_seed (load_seed),
    .o_step      (step),
    .o_result    (result),
    .o_prev      (prev),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LFSR datapath model.
  always @(posedge clk) begin
    if (load_seed) rnd <= 4'd15;
    else if (step) rnd <= {rnd[3] ^ rnd[0], rnd[3:1]};
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin : mon
    done_t d;
    if (rst_n) begin
      if (load_seed) begin
        if (load_q.size() == 0) check("load_unexpected", cyc, -1);
        else check("load_cycle", cyc, load_q.pop_front());
      end
      if (step) begin
        check("step_with_load", int'(load_seed), 0);
        if (step_q.size() == 0) check("step_unexpected", cyc, -1);
        else check("step_cycle", cyc, step_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", cyc, -1);
        else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_result", int'(result), d.res);
          check("done_prev", int'(prev), d.prv);
        end
      end
    end
  end

  task automatic wait_rel(input int base, input int rel);
    while (cyc < base + rel) @(negedge clk);
  endtask

  task automatic kick(output int base);
    @(negedge clk);
    base  = cyc;
    start = 1'b1;
    load_q.push_back(base + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_steps(input int base, input int n);
    for (int i = 0; i < n; i++) step_q.push_back(base + step_ofs[i]);
  endtask

  task automatic push_done(input int c, input int res, input int prv);
    done_t d;
    d.cyc = c;
    d.res = res;
    d.prv = prv;
    done_q.push_back(d);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},   int'(load_seed), 0);
    check({tag, "_step"},   int'(step),      0);
    check({tag, "_done"},   int'(done),      0);
    check({tag, "_busy"},   int'(busy),      0);
    check({tag, "_result"}, int'(result),    0);
    check({tag, "_prev"},   int'(prev),      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full roll from reset.
    kick(b);
    push_steps(b, 6);
    push_done(b + 58, 6, 0);
    check("busy_c1", int'(busy), 1);
    wait_rel(b, 6);
    check("anim_c6", int'(result), 7);
    wait_rel(b, 57);
    check("busy_c57", int'(busy), 1);
    wait_rel(b, 58);
    check("busy_c58", int'(busy), 0);
    wait_rel(b, 62);

    // Second full roll; history shifts.
    kick(b);
    push_steps(b, 6);
    push_done(b + 58, 6, 6);
    wait_rel(b, 62);
    check("prev_after_2", int'(prev), 6);

    // Early stop with no coincident step.
    kick(b);
    push_steps(b, 2);
    push_done(b + 12, 11, 6);
    wait_rel(b, 10);
    pulse_stop();
    wait_rel(b, 20);
    recall = 1'b1;
    repeat (2) @(negedge clk);
    check("recall_on", int'(result), 6);
    recall = 1'b0;
    repeat (2) @(negedge clk);
    check("recall_off", int'(result), 11);

    // Early stop coinciding with a step.
    kick(b);
    push_steps(b, 3);
    push_done(b + 18, 5, 11);
    wait_rel(b, 16);
    pulse_stop();
    wait_rel(b, 25);

    // Restart mid-roll.
    kick(b);
    push_steps(b, 3);
    wait_rel(b, 20);
    start = 1'b1;
    load_q.push_back(b + 21);
    @(negedge clk);
    start = 1'b0;
    push_steps(b + 20, 6);
    push_done(b + 78, 6, 5);
    wait_rel(b, 77);
    check("prev_hold_restart", int'(prev), 11);
    wait_rel(b, 82);

    // Asynchronous reset mid-roll.
    kick(b);
    push_steps(b, 4);
    wait_rel(b, 30);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);

    check("load_q_left", load_q.size(), 0);
    check("step_q_left", step_q.size(), 0);
    check("done_q_left", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
